cla_seq_adder: RTL and testbench

Parametrised, multi-cycle carry-lookahead adder/subtractor for the multi-cycle CPU datapath. Each cycle it adds one SLICE-bit group of the operands with a 4-bit-style lookahead generator and registers the inter-group carry, so WIDTH bits complete in WIDTH/SLICE cycles. It adds a subtract mode, carry/borrow-in, a valid/ready handshake on both sides, and cout/overflow/zero flags. The ALU and address-calculation paths use it as a shared arithmetic resource.

---
 rtl/cla_seq_adder.sv | 138 +++++++++++++
 tb/tb_cla_seq_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
`timescale 1ns/1ps
// Multi-cycle carry-lookahead adder/subtractor, one SLICE-bit group per cycle.
// Latency: result valid WIDTH/SLICE cycles after the accepting edge.
// Backpressure: result held while out_ready=0; next op accepted on the result handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b, sub, cin sampled on accept)
//   out_valid/out_ready   result handshake (sum, cout, ovf, zero)
module cla_seq_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic             accept, last;

  logic [SLICE-1:0] sl_a, sl_b, g, p, s;
  logic [SLICE:0]   c;
  logic [WIDTH-1:0] res_nxt;

  assign accept = in_valid && in_ready;
  assign last   = (k == K_LAST);
  assign sl_a   = op_a[int'(k)*SLICE +: SLICE];
  assign sl_b   = op_b[int'(k)*SLICE +: SLICE];
  assign g      = sl_a & sl_b;
  assign p      = sl_a ^ sl_b;

  // Flattened lookahead: each group carry is the OR of every generate term
  // propagated up to it plus the incoming carry propagated through all
  // lower bits, so no ripple chain exists inside the slice.
  always_comb begin
    logic pp;
    logic acc;
    pp   = 1'b1;
    acc  = 1'b0;
    c    = '0;
    c[0] = carry;
    for (int i = 0; i < SLICE; i++) begin
      pp  = 1'b1;
      acc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (g[j] & pp);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & carry);
    end
  end

  assign s = p ^ c[SLICE-1:0];

  always_comb begin
    res_nxt = res;
    res_nxt[int'(k)*SLICE +: SLICE] = s;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  // Datapath: subtraction is A + ~B + ~borrow, so cout=1 means no borrow.
  // Result registers only change on entry to DONE so sum and flags always
  // come from the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      k     <= '0;
      res   <= '0;
    end else if (state == RUN) begin
      res   <= res_nxt;
      carry <= c[SLICE];
      if (last) begin
        sum  <= res_nxt;
        cout <= c[SLICE];
        ovf  <= c[SLICE] ^ c[SLICE-1];
        zero <= (res_nxt == '0);
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
`timescale 1ns/1ps
module tb_cla_seq_adder;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance X: WIDTH=32, SLICE=4
  logic        x_in_valid = 1'b0, x_in_ready, x_sub = 1'b0, x_cin = 1'b0;
  logic        x_out_valid, x_out_ready = 1'b1, x_cout, x_ovf, x_zero;
  logic [31:0] x_a = '0, x_b = '0, x_sum;

  // Instance Y: WIDTH=32, SLICE=32
  logic        y_in_valid = 1'b0, y_in_ready, y_sub = 1'b0, y_cin = 1'b0;
  logic        y_out_valid, y_out_ready = 1'b1, y_cout, y_ovf, y_zero;
  logic [31:0] y_a = '0, y_b = '0, y_sum;

  cla_seq_adder #(.WIDTH(32), .SLICE(4)) u_x (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a(x_a), .b(x_b), .sub(x_sub), .cin(x_cin),
    .out_valid(x_out_valid), .out_ready(x_out_ready),
    .sum(x_sum), .cout(x_cout), .ovf(x_ovf), .zero(x_zero)
  );

  cla_seq_adder #(.WIDTH(32), .SLICE(32)) u_y (
    .clk(clk), .rst(rst), .in_valid(y_in_valid), .in_ready(y_in_ready),
    .a(y_a), .b(y_b), .sub(y_sub), .cin(y_cin),
    .out_valid(y_out_valid), .out_ready(y_out_ready),
    .sum(y_sum), .cout(y_cout), .ovf(y_ovf), .zero(y_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Arithmetic reference: 33-bit sum of A, the (possibly inverted) B and the
  // effective carry; overflow from the operand/result sign rule.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic sv, input logic cv, input int acc);
    exp_t        m;
    logic [31:0] bo;
    logic [32:0] t;
    bo    = sv ? ~bv : bv;
    t     = {1'b0, av} + {1'b0, bo} + {32'b0, (sv ? ~cv : cv)};
    m.s   = t[31:0];
    m.c   = t[32];
    m.o   = (av[31] == bo[31]) && (t[31] != av[31]);
    m.z   = (t[31:0] == 32'd0);
    m.acc = acc;
    return m;
  endfunction

  // Scoreboards: an op seen accepted before the edge at negedge n is
  // expected valid from negedge n+NSLICE+1 until consumed.
  exp_t xq[$];
  exp_t xheld = '{32'd0, 1'b0, 1'b0, 1'b0, 0};
  int   xcyc = 0;
  always @(negedge clk) begin
    logic xov, xir;
    exp_t f;
    xcyc++;
    if (rst) begin
      xq.delete();
      xheld = '{32'd0, 1'b0, 1'b0, 1'b0, 0};
    end
    xov = (xq.size() > 0) && ((xcyc - xq[0].acc) >= 9);
    f   = xov ? xq[0] : xheld;
    xir = rst || (xq.size() == 0) || (xov && x_out_ready);
    chk("x_out_valid", x_out_valid, xov);
    chk("x_in_ready", x_in_ready, xir);
    chk("x_sum", x_sum, f.s);
    chk("x_cout", x_cout, f.c);
    chk("x_ovf", x_ovf, f.o);
    chk("x_zero", x_zero, f.z);
    if (!rst) begin
      if (xov && x_out_ready) xheld = xq.pop_front();
      if (x_in_valid && xir) xq.push_back(model(x_a, x_b, x_sub, x_cin, xcyc));
    end
  end

  exp_t yq[$];
  exp_t yheld = '{32'd0, 1'b0, 1'b0, 1'b0, 0};
  int   ycyc = 0;
  always @(negedge clk) begin
    logic yov, yir;
    exp_t f;
    ycyc++;
    if (rst) begin
      yq.delete();
      yheld = '{32'd0, 1'b0, 1'b0, 1'b0, 0};
    end
    yov = (yq.size() > 0) && ((ycyc - yq[0].acc) >= 2);
    f   = yov ? yq[0] : yheld;
    yir = rst || (yq.size() == 0) || (yov && y_out_ready);
    chk("y_out_valid", y_out_valid, yov);
    chk("y_in_ready", y_in_ready, yir);
    chk("y_sum", y_sum, f.s);
    chk("y_cout", y_cout, f.c);
    chk("y_ovf", y_ovf, f.o);
    chk("y_zero", y_zero, f.z);
    if (!rst) begin
      if (yov && y_out_ready) yheld = yq.pop_front();
      if (y_in_valid && yir) yq.push_back(model(y_a, y_b, y_sub, y_cin, ycyc));
    end
  end

  // Present an op on X and hold it until accepted; inputs are scrambled
  // afterwards so any late sampling shows up as a wrong result.
  task automatic x_op(input logic [31:0] av, input logic [31:0] bv,
                      input logic sv, input logic cv);
    int n = 0;
    x_a = av; x_b = bv; x_sub = sv; x_cin = cv; x_in_valid = 1'b1;
    while (!x_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!x_in_ready) bound_fail("x_accept");
    @(posedge clk); #1;
    x_in_valid = 1'b0;
    x_a = ~av; x_b = ~bv; x_sub = ~sv; x_cin = ~cv;
  endtask

  task automatic x_wait(input int lat);
    int n = 0;
    while (!x_out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!x_out_valid) bound_fail("x_result");
    else chk("x_latency", n, lat);
  endtask

  task automatic x_res(input string nm, input logic [31:0] s, input logic c,
                       input logic o, input logic z);
    chk({nm, "_sum"}, x_sum, s);
    chk({nm, "_cout"}, x_cout, c);
    chk({nm, "_ovf"}, x_ovf, o);
    chk({nm, "_zero"}, x_zero, z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", x_in_ready, 1);
    chk("rst_out_valid", x_out_valid, 0);
    chk("rst_sum", x_sum, 0);

    // Carry ripples across four slices
    x_op(32'h0000FFFF, 32'd1, 1'b0, 1'b0);
    x_wait(8);
    x_res("t1", 32'h00010000, 0, 0, 0);

    // Backpressure: result held five cycles, then same-cycle accept
    x_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    x_out_ready = 1'b0;
    x_wait(8);
    x_res("t4", 32'h23456789, 0, 0, 0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", x_out_valid, 1);
      chk("t4_hold_in_ready", x_in_ready, 0);
      x_res("t4_hold", 32'h23456789, 0, 0, 0);
    end
    x_out_ready = 1'b1;
    #1 chk("t4_in_ready", x_in_ready, 1);
    x_op(32'd1, 32'd2, 1'b0, 1'b0);
    x_wait(8);
    x_res("t4b", 32'd3, 0, 0, 0);

    // Subtract, with and without borrow-in
    x_op(32'd5, 32'd5, 1'b1, 1'b0);
    x_wait(8);
    x_res("t3a", 32'd0, 1, 0, 1);
    x_op(32'd0, 32'd1, 1'b1, 1'b0);
    x_wait(8);
    x_res("t3b", 32'hFFFFFFFF, 0, 0, 0);
    x_op(32'd10, 32'd3, 1'b1, 1'b1);
    x_wait(8);
    x_res("t3c", 32'd6, 1, 0, 0);

    // Wrap to zero, then signed overflow
    x_op(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    x_wait(8);
    x_res("t2b", 32'd0, 1, 0, 1);
    x_op(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
    x_wait(8);
    x_res("t2a", 32'h80000000, 0, 1, 0);

    // Reset in the middle of RUN (k=3) discards the op
    x_op(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_out_valid", x_out_valid, 0);
    chk("t5_in_ready", x_in_ready, 1);
    x_res("t5", 32'd0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    x_op(32'd2, 32'd3, 1'b0, 1'b0);
    x_wait(8);
    x_res("t5b", 32'd5, 0, 0, 0);

    // Single-slice instance: latency 1
    y_a = 32'hFFFFFFFF; y_b = 32'd0; y_sub = 1'b0; y_cin = 1'b1; y_in_valid = 1'b1;
    #1 chk("t6_in_ready", y_in_ready, 1);
    @(posedge clk); #1;
    y_in_valid = 1'b0;
    y_a = '0; y_cin = 1'b0;
    n = 0;
    while (!y_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!y_out_valid) bound_fail("y_result");
    else chk("t6_latency", n, 1);
    chk("t6_sum", y_sum, 32'd0);
    chk("t6_cout", y_cout, 1);
    chk("t6_ovf", y_ovf, 0);
    chk("t6_zero", y_zero, 1);

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
